// File: rtl/microwave_controller_if.sv
// Signal bundle between the microwave front panel / countdown timer and
// microwave_controller. master = controller side, slave = panel/timer side.
interface microwave_controller_if;
    // key_valid, start_btn and stop_btn are single-cycle strobes with no ready:
    // the controller samples them every rising edge and drops any it cannot use.
    logic       key_valid;
    logic [3:0] key_code;
    logic       start_btn;
    logic       stop_btn;
    logic       door_open;
    logic       timer_finished;
    logic       timer_load;
    logic [3:0] timer_digit;
    logic       timer_enabled;
    logic       magnetron_on;
    logic       beep;
    logic [2:0] digit_count;
    logic [2:0] state;

    modport master (
        input  key_valid, key_code, start_btn, stop_btn, door_open, timer_finished,
        output timer_load, timer_digit, timer_enabled, magnetron_on, beep,
               digit_count, state
    );

    modport slave (
        output key_valid, key_code, start_btn, stop_btn, door_open, timer_finished,
        input  timer_load, timer_digit, timer_enabled, magnetron_on, beep,
               digit_count, state
    );
endinterface

// File: rtl/microwave_controller.sv
// Front-panel FSM feeding a 4-digit BCD countdown timer: key loading, cook ticks,
// door interlock and end beep. Define MICROWAVE_QUICK_START_EN for the 00:30 quick start.
module microwave_controller #(
    parameter int TICK_DIV    = 50000000,
    parameter int BEEP_CYCLES = 100000000
) (
    input logic                    clk,
    input logic                    rst,
    microwave_controller_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_COOK    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_CLEAR   = 3'd5,
        ST_PRELOAD = 3'd6
    } state_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic [2:0]    seq_cnt_q, seq_cnt_d;
    logic          tick_seen_q, tick_seen_d;
    logic [2:0]    digit_count_q, digit_count_d;
    logic          timer_load_q, timer_load_d;
    logic [3:0]    timer_digit_q, timer_digit_d;
    logic          timer_enabled_q, timer_enabled_d;
    logic          magnetron_on_q, magnetron_on_d;
    logic          beep_q, beep_d;
    logic          valid_digit;
    logic          go_clear;

    assign valid_digit = bus.key_valid && (bus.key_code <= 4'd9);

    always_comb begin
        state_d         = state_q;
        presc_d         = presc_q;
        beep_cnt_d      = beep_cnt_q;
        seq_cnt_d       = seq_cnt_q;
        tick_seen_d     = tick_seen_q;
        digit_count_d   = digit_count_q;
        magnetron_on_d  = magnetron_on_q;
        beep_d          = beep_q;
        timer_load_d    = 1'b0;
        timer_digit_d   = 4'd0;
        timer_enabled_d = 1'b0;
        go_clear        = 1'b0;

        case (state_q)
            ST_IDLE: begin
`ifdef MICROWAVE_QUICK_START_EN
                if (!bus.stop_btn && bus.start_btn && !bus.door_open) begin
                    state_d       = ST_PRELOAD;
                    timer_load_d  = 1'b1;
                    seq_cnt_d     = 3'd1;
                    digit_count_d = 3'd1;
                end
`endif
                if (!bus.stop_btn && !bus.start_btn && valid_digit) begin
                    state_d       = ST_ENTRY;
                    timer_load_d  = 1'b1;
                    timer_digit_d = bus.key_code;
                    digit_count_d = 3'd1;
                end
            end

            ST_ENTRY: begin
                if (bus.stop_btn) begin
                    go_clear = 1'b1;
                end else if (bus.start_btn) begin
                    if (!bus.door_open) begin
                        state_d        = ST_COOK;
                        magnetron_on_d = 1'b1;
                        tick_seen_d    = 1'b0;
                    end
                end else if (valid_digit && (digit_count_q < 3'd4)) begin
                    timer_load_d  = 1'b1;
                    timer_digit_d = bus.key_code;
                    digit_count_d = digit_count_q + 3'd1;
                end
            end

            ST_COOK: begin
                // A finished flag seen before our first tick is left over from a previous cook.
                if (bus.timer_finished && tick_seen_q) begin
                    state_d        = ST_DONE;
                    magnetron_on_d = 1'b0;
                    beep_d         = 1'b1;
                    beep_cnt_d     = BW'(1);
                end else if (bus.door_open || bus.stop_btn) begin
                    state_d        = ST_PAUSE;
                    magnetron_on_d = 1'b0;
                end else if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d         = '0;
                    timer_enabled_d = 1'b1;
                    tick_seen_d     = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            ST_PAUSE: begin
                if (bus.stop_btn) begin
                    go_clear = 1'b1;
                end else if (bus.start_btn && !bus.door_open) begin
                    state_d        = ST_COOK;
                    magnetron_on_d = 1'b1;
                end
            end

            ST_DONE: begin
                if (bus.stop_btn || (!bus.start_btn && valid_digit)) begin
                    go_clear = 1'b1;
                end else if (beep_cnt_q == BW'(BEEP_CYCLES)) begin
                    go_clear = 1'b1;
                end else begin
                    beep_cnt_d = beep_cnt_q + BW'(1);
                end
            end

            ST_CLEAR: begin
                // seq_cnt_q counts zero-load pulses already issued.
                if (seq_cnt_q == 3'd4) begin
                    state_d       = ST_IDLE;
                    seq_cnt_d     = 3'd0;
                    digit_count_d = 3'd0;
                    presc_d       = '0;
                    tick_seen_d   = 1'b0;
                end else begin
                    timer_load_d = 1'b1;
                    seq_cnt_d    = seq_cnt_q + 3'd1;
                end
            end

`ifdef MICROWAVE_QUICK_START_EN
            ST_PRELOAD: begin
                if (bus.stop_btn) begin
                    go_clear = 1'b1;
                end else if (seq_cnt_q == 3'd4) begin
                    state_d        = ST_COOK;
                    seq_cnt_d      = 3'd0;
                    magnetron_on_d = 1'b1;
                    tick_seen_d    = 1'b0;
                end else begin
                    timer_load_d  = 1'b1;
                    timer_digit_d = (seq_cnt_q == 3'd2) ? 4'd3 : 4'd0;
                    seq_cnt_d     = seq_cnt_q + 3'd1;
                    digit_count_d = seq_cnt_q + 3'd1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The first of the four zero loads goes out on the edge that enters CLEAR.
        if (go_clear) begin
            state_d        = ST_CLEAR;
            timer_load_d   = 1'b1;
            timer_digit_d  = 4'd0;
            seq_cnt_d      = 3'd1;
            magnetron_on_d = 1'b0;
            beep_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            presc_q         <= '0;
            beep_cnt_q      <= '0;
            seq_cnt_q       <= 3'd0;
            tick_seen_q     <= 1'b0;
            digit_count_q   <= 3'd0;
            timer_load_q    <= 1'b0;
            timer_digit_q   <= 4'd0;
            timer_enabled_q <= 1'b0;
            magnetron_on_q  <= 1'b0;
            beep_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            presc_q         <= presc_d;
            beep_cnt_q      <= beep_cnt_d;
            seq_cnt_q       <= seq_cnt_d;
            tick_seen_q     <= tick_seen_d;
            digit_count_q   <= digit_count_d;
            timer_load_q    <= timer_load_d;
            timer_digit_q   <= timer_digit_d;
            timer_enabled_q <= timer_enabled_d;
            magnetron_on_q  <= magnetron_on_d;
            beep_q          <= beep_d;
        end
    end

    assign bus.timer_load    = timer_load_q;
    assign bus.timer_digit   = timer_digit_q;
    assign bus.timer_enabled = timer_enabled_q;
    assign bus.magnetron_on  = magnetron_on_q;
    assign bus.beep          = beep_q;
    assign bus.digit_count   = digit_count_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Bench for microwave_controller: hand-written vector table, directed cook/pause/done
// sequences, then random stimulus against a queue-based behavioural model.
module tb_microwave_controller;

    localparam int TICK = 4;
    localparam int BEEP = 6;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4,
                   M_CLEAR = 5, M_PRE = 6;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    microwave_controller_if bus();

    microwave_controller #(.TICK_DIV(TICK), .BEEP_CYCLES(BEEP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       st, sp, dr;
        logic       ld;
        logic [3:0] dg;
        logic [2:0] cnt;
        logic [2:0] state;
        logic       mag;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input int kv, kc, st, sp, dr, ld, dg, cnt, state, mag);
        vec_t v;
        v.kv = 1'(kv); v.kc = 4'(kc); v.st = 1'(st); v.sp = 1'(sp); v.dr = 1'(dr);
        v.ld = 1'(ld); v.dg = 4'(dg); v.cnt = 3'(cnt); v.state = 3'(state); v.mag = 1'(mag);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit kv, input bit [3:0] kc, input bit st, input bit sp,
                         input bit dr, input bit fin);
        bus.key_valid      = kv;
        bus.key_code       = kc;
        bus.start_btn      = st;
        bus.stop_btn       = sp;
        bus.door_open      = dr;
        bus.timer_finished = fin;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        drive(0, 0, 0, 0, 0, 0);
        while (bus.state != 3'd0 && n < 20) begin
            cyc();
            n++;
        end
        chk("wait_idle", 32'(bus.state), 0);
    endtask

    // Behavioural model: pending timer loads live in a queue, cooking is a count of
    // heated cycles with a tick on every TICK-th one.
    int         m_mode, m_entered, m_cooked, m_beep_left;
    bit         m_ticked;
    int         m_pend[$];
    logic       m_load, m_tick;
    logic [3:0] m_digit;

    task automatic model_reset();
        m_mode = M_IDLE; m_entered = 0; m_cooked = 0; m_beep_left = 0; m_ticked = 0;
        m_pend.delete();
    endtask

    task automatic model_pop();
        m_load  = 1'b1;
        m_digit = 4'(m_pend.pop_front());
    endtask

    task automatic model_clear();
        m_pend = '{0, 0, 0, 0};
        m_mode = M_CLEAR;
        model_pop();
    endtask

    task automatic model_step(input bit kv, input bit [3:0] kc, input bit st, input bit sp,
                              input bit dr, input bit fin);
        bit dig;
        dig = kv && (kc <= 4'd9);
        m_load = 1'b0; m_digit = 4'd0; m_tick = 1'b0;
        case (m_mode)
            M_IDLE: begin
`ifdef MICROWAVE_QUICK_START_EN
                if (!sp && st && !dr) begin
                    m_pend = '{0, 0, 3, 0};
                    m_mode = M_PRE;
                    model_pop();
                    m_entered = 1;
                end
`endif
                if (!sp && !st && dig) begin
                    m_load = 1'b1; m_digit = kc; m_entered = 1; m_mode = M_ENTRY;
                end
            end
            M_ENTRY: begin
                if (sp) model_clear();
                else if (st) begin
                    if (!dr) begin m_mode = M_COOK; m_ticked = 0; end
                end else if (dig && m_entered < 4) begin
                    m_load = 1'b1; m_digit = kc; m_entered++;
                end
            end
            M_COOK: begin
                if (fin && m_ticked) begin
                    m_mode = M_DONE; m_beep_left = BEEP;
                end else if (dr || sp) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_cooked++;
                    if (m_cooked % TICK == 0) begin m_tick = 1'b1; m_ticked = 1; end
                end
            end
            M_PAUSE: begin
                if (sp) model_clear();
                else if (st && !dr) m_mode = M_COOK;
            end
            M_DONE: begin
                if (sp || (!st && dig)) model_clear();
                else begin
                    m_beep_left--;
                    if (m_beep_left == 0) model_clear();
                end
            end
            M_CLEAR: begin
                if (m_pend.size() > 0) model_pop();
                else begin m_mode = M_IDLE; m_entered = 0; m_cooked = 0; end
            end
            M_PRE: begin
                if (sp) model_clear();
                else if (m_pend.size() > 0) begin model_pop(); m_entered++; end
                else begin m_mode = M_COOK; m_ticked = 0; end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [13:0] dut_vec();
        return {bus.timer_load, bus.timer_digit, bus.timer_enabled, bus.magnetron_on,
                bus.beep, bus.digit_count, bus.state};
    endfunction

    initial begin
        bit         kv, st, sp, dr, fin;
        bit   [3:0] kc;
        logic [13:0] exp_v;
        int         qd[4];

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vec", 32'(dut_vec()), 0);
        rst = 1'b1;
        cyc();
        chk("reset_idle", 32'(dut_vec()), 0);

        // Keys, overflow, invalid codes, stop+start priority, door-open start, clear.
        vecs[0]  = mk(1, 1, 0, 0, 0, 1, 1, 1, 1, 0);
        vecs[1]  = mk(1, 2, 0, 0, 0, 1, 2, 2, 1, 0);
        vecs[2]  = mk(1, 3, 0, 0, 0, 1, 3, 3, 1, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 1, 0, 4, 1, 0);
        vecs[4]  = mk(1, 7, 0, 0, 0, 0, 0, 4, 1, 0);
        vecs[5]  = mk(1, 12, 0, 0, 0, 0, 0, 4, 1, 0);
        vecs[6]  = mk(1, 8, 1, 1, 0, 1, 0, 4, 5, 0);
        vecs[7]  = mk(1, 5, 0, 0, 0, 1, 0, 4, 5, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 1, 0, 4, 5, 0);
        vecs[9]  = mk(0, 0, 0, 1, 0, 1, 0, 4, 5, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 9, 0, 0, 0, 1, 9, 1, 1, 0);
        vecs[14] = mk(0, 0, 1, 0, 1, 0, 0, 1, 1, 0);
        vecs[15] = mk(1, 4, 0, 0, 1, 1, 4, 2, 1, 0);
        vecs[16] = mk(0, 0, 0, 1, 0, 1, 0, 2, 5, 0);
        vecs[17] = mk(1, 5, 0, 0, 0, 1, 0, 2, 5, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 1, 0, 2, 5, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 2, 5, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].kv, vecs[i].kc, vecs[i].st, vecs[i].sp, vecs[i].dr, 0);
            cyc();
            chk($sformatf("vec%0d", i),
                32'({bus.timer_load, bus.timer_digit, bus.digit_count, bus.state, bus.magnetron_on}),
                32'({vecs[i].ld, vecs[i].dg, vecs[i].cnt, vecs[i].state, vecs[i].mag}));
        end

        // Full cook: five ticks, finished, six beep cycles, four zero loads.
        drive(1, 5, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 0, 0, 0); cyc();
        chk("cook_mag", 32'(bus.magnetron_on), 1);
        chk("cook_state", 32'(bus.state), 2);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk($sformatf("tick_%0d", i), 32'(bus.timer_enabled), 32'(i % TICK == 0));
        end
        drive(0, 0, 0, 0, 0, 1); cyc();
        chk("done_vec", 32'({bus.state, bus.beep, bus.magnetron_on}), 32'({3'd4, 1'b1, 1'b0}));
        drive(0, 0, 0, 0, 0, 0);
        for (int j = 2; j <= BEEP; j++) begin
            cyc();
            chk($sformatf("beep_%0d", j), 32'(bus.beep), 1);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("clr_load_%0d", k),
                32'({bus.beep, bus.state, bus.timer_load, bus.timer_digit}),
                32'({1'b0, 3'd5, 1'b1, 4'd0}));
        end
        cyc();
        chk("clr_end", 32'({bus.state, bus.digit_count, bus.timer_load}), 0);

        // Pause with the prescaler at 2, resume: next tick two cycles later.
        drive(1, 5, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk($sformatf("p_tick_%0d", i), 32'(bus.timer_enabled), 32'(i == 4));
        end
        drive(0, 0, 0, 0, 1, 0); cyc();
        chk("pause_state", 32'({bus.state, bus.magnetron_on}), 32'({3'd3, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("pause_hold_%0d", i), 32'({bus.state, bus.timer_enabled}), 32'({3'd3, 1'b0}));
        end
        drive(0, 0, 1, 0, 0, 0); cyc();
        chk("resume", 32'({bus.state, bus.magnetron_on}), 32'({3'd2, 1'b1}));
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("resume_t1", 32'(bus.timer_enabled), 0);
        cyc();
        chk("resume_t2", 32'(bus.timer_enabled), 1);
        drive(0, 0, 0, 1, 0, 0); cyc();
        chk("stop_cook", 32'(bus.state), 3);
        cyc();
        chk("stop_pause", 32'(bus.state), 5);
        wait_idle();

        // Stale finished flag ignored until a tick; finished beats door in the same cycle.
        drive(1, 5, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("stale_%0d", i), 32'({bus.state, bus.timer_enabled}),
                32'({3'd2, 1'(i == 4)}));
        end
        drive(0, 0, 0, 0, 1, 1); cyc();
        chk("fin_over_door", 32'(bus.state), 4);
        drive(0, 0, 0, 1, 0, 0); cyc();
        chk("beep_stop", 32'({bus.state, bus.beep, bus.timer_load}), 32'({3'd5, 1'b0, 1'b1}));
        wait_idle();

        // Start in IDLE with the door closed.
        drive(0, 0, 1, 0, 0, 0); cyc();
`ifdef MICROWAVE_QUICK_START_EN
        qd = '{0, 0, 3, 0};
        drive(0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 4; p++) begin
            if (p > 0) cyc();
            chk($sformatf("qs_%0d", p),
                32'({bus.timer_load, bus.timer_digit, bus.digit_count, bus.state}),
                32'({1'b1, 4'(qd[p]), 3'(p + 1), 3'd6}));
        end
        cyc();
        chk("qs_cook", 32'({bus.state, bus.magnetron_on}), 32'({3'd2, 1'b1}));
        drive(0, 0, 0, 1, 0, 0); cyc(); cyc();
        wait_idle();
`else
        qd = '{0, 0, 0, 0};
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_start_0", 32'(dut_vec()), 32'(qd[0]));
        cyc();
        chk("idle_start_1", 32'(dut_vec()), 32'(qd[1]));
`endif

        // Asynchronous reset in the middle of cooking.
        drive(1, 5, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
        #3 rst = 1'b0;
        #1;
        chk("async_rst", 32'(dut_vec()), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();

        dr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            kv  = ($urandom_range(0, 99) < 25);
            kc  = 4'($urandom_range(0, 11));
            st  = ($urandom_range(0, 99) < 12);
            sp  = ($urandom_range(0, 99) < 3);
            fin = ($urandom_range(0, 99) < 6);
            if (!dr && $urandom_range(0, 99) < 3) dr = 1'b1;
            else if (dr && $urandom_range(0, 99) < 20) dr = 1'b0;
            drive(kv, kc, st, sp, dr, fin);
            cyc();
            model_step(kv, kc, st, sp, dr, fin);
            exp_v = {m_load, m_digit, m_tick, 1'(m_mode == M_COOK), 1'(m_mode == M_DONE),
                     3'(m_entered), 3'(m_mode)};
            chk($sformatf("rand_%0d", n), 32'(dut_vec()), 32'(exp_v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
